cam_core: RTL and testbench
===========================

CAM_CORE -- requirements
Module: cam_core

Interface
REQ-001 Parameter: NUM_ENTRIES, default 8, number of key/value entries.
REQ-002 Parameter: KEY_WIDTH, default 16, key width in bits.
REQ-003 Parameter: DATA_WIDTH, default 16, value width in bits.
REQ-004 Port: clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: valid_i  in  1  request strobe; 1 = the request is sampled this edge.
REQ-007 Port: rw_n_i  in  1  request type; 1 = read, 0 = write.
REQ-008 Port: key_i  in  KEY_WIDTH  lookup/store key.
REQ-009 Port: val_i  in  DATA_WIDTH  write data; ignored on reads.
REQ-010 Port: valid_o  out  1  read-hit indication for the previous-cycle read.
REQ-011 Port: val_o  out  DATA_WIDTH  read data for the previous-cycle read; 0 when valid_o=0.

Function
REQ-012 Storage SHALL be NUM_ENTRIES entries, each holding {valid, key, value}, with a true-LRU order over all entries.
REQ-013 One request per cycle; no backpressure; a request is accepted on every edge where valid_i=1 and rst_n=1.
REQ-014 Read: on a key match with a valid entry, the block SHALL register valid_o=1 and val_o=entry value at the sampling edge, visible for exactly one cycle (latency 1).
REQ-015 Read miss SHALL give valid_o=0, val_o=0 and SHALL NOT change the LRU order.
REQ-016 Read hit SHALL make the hit entry most-recently-used (MRU).
REQ-017 Write hit (valid entry with equal key) SHALL overwrite that entry's value in place, make it MRU, and allocate no new entry.
REQ-018 Write miss with at least one invalid entry SHALL fill the lowest-index invalid entry and make it MRU.
REQ-019 Write miss with all entries valid SHALL evict and replace the LRU entry and make it MRU.
REQ-020 At most one valid entry SHALL hold a given key at any time.
REQ-021 Write at edge N followed by read of the same key at edge N+1 SHALL return the value written at edge N.
REQ-022 Two writes to the same key on consecutive edges SHALL leave one entry holding the second value.
REQ-023 LRU state SHALL be a permutation of entry indices (or equivalent age counters of width clog2(NUM_ENTRIES)); every update SHALL keep it a valid permutation.
REQ-024 Cycles with valid_i=0 SHALL leave storage and LRU unchanged and SHALL drive valid_o=0, val_o=0 on the following cycle.

Reset
REQ-025 While rst_n=0 at an edge, the block SHALL clear all entry valid bits, set valid_o=0 and val_o=0, and set the LRU order to index order (entry 0 = LRU, entry NUM_ENTRIES-1 = MRU).
REQ-026 A request presented on the same edge as rst_n=0 SHALL be discarded.
REQ-027 Reset asserted mid-sequence SHALL lose all stored data; a subsequent read of any key SHALL miss.
REQ-028 Key and value storage need not be cleared by reset; only valid bits are architecturally visible.

Verification
REQ-029 Reset, write (0x0001,0xAAAA), read 0x0001 -> next cycle valid_o=1, val_o=0xAAAA; read 0x0002 -> valid_o=0, val_o=0.
REQ-030 Write (0x0010,0x1111) at edge N, write (0x0010,0x2222) at N+1, read 0x0010 at N+2 -> valid_o=1, val_o=0x2222, only one entry valid.
REQ-031 Write keys 0x00..0x07 (values = key), read 0x00, write 0x08 -> entry holding 0x01 is evicted: read 0x01 misses, read 0x00 hits with 0x0000, read 0x08 hits with 0x0008.
REQ-032 Fill 8 keys, read miss of 0x99, write 0x09 -> evicts key 0x00 (read miss did not touch LRU).
REQ-033 Write (0x0005,0x5555), assert rst_n=0 one cycle together with a write (0x0006,0x6666), release, read 0x0005 and 0x0006 -> both valid_o=0.
REQ-034 Random back-to-back reads/writes over 12 keys checked against a reference model -> zero valid_o/val_o mismatches; every entry index hit and evicted at least once.

Source files
------------

// File: rtl/cam_core.sv
// cam_core: key/value CAM with true-LRU replacement; ports clk, rst_n, valid_i, rw_n_i, key_i, val_i -> valid_o, val_o (one-cycle read latency)
module cam_core #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  rw_n_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic [DATA_WIDTH-1:0] val_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] val_o
);
  localparam int AW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
  logic [NUM_ENTRIES-1:0] vld;
  logic [KEY_WIDTH-1:0]   keys [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  vals [NUM_ENTRIES];
  // rank 0 = LRU, rank NUM_ENTRIES-1 = MRU; ranks always form a permutation
  logic [AW-1:0]          rank [NUM_ENTRIES];
  logic                   hit, has_free, touch, rd_hit;
  logic [AW-1:0]          hit_idx, free_idx, lru_idx, tgt;
  always_comb begin
    hit = 1'b0;
    has_free = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    lru_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (vld[i] && keys[i] == key_i) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
      if (!vld[i]) begin
        has_free = 1'b1;
        free_idx = AW'(i);
      end
      if (rank[i] == '0) lru_idx = AW'(i);
    end
    tgt = hit ? hit_idx : has_free ? free_idx : lru_idx;
    rd_hit = valid_i && rw_n_i && hit;
    touch = valid_i && (!rw_n_i || hit);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      valid_o <= 1'b0;
      val_o <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) rank[i] <= AW'(i);
    end else begin
      valid_o <= rd_hit;
      val_o <= rd_hit ? vals[hit_idx] : '0;
      if (valid_i && !rw_n_i) begin
        vld[tgt] <= 1'b1;
        keys[tgt] <= key_i;
        vals[tgt] <= val_i;
      end
      if (touch)
        for (int i = 0; i < NUM_ENTRIES; i++)
          rank[i] <= AW'(i) == tgt ? AW'(NUM_ENTRIES - 1) :
                     rank[i] > rank[tgt] ? rank[i] - AW'(1) : rank[i];
    end
  end
endmodule

// File: tb/tb_cam_core.sv
// tb_cam_core: scoreboard bench for cam_core; directed vectors plus a list-ordered LRU reference model
module tb_cam_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        rw_n_i = 1'b0;
  logic [15:0] key_i = '0;
  logic [15:0] val_i = '0;
  logic        valid_o;
  logic [15:0] val_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct {
    logic        v;
    logic [15:0] d;
    string       nm;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] mkey [8];
  logic [15:0] mval [8];
  bit          mvld [8];
  int          order[$];
  cam_core #(.NUM_ENTRIES(8), .KEY_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .rw_n_i(rw_n_i),
    .key_i(key_i), .val_i(val_i), .valid_o(valid_o), .val_o(val_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (valid_o !== e.v || val_o !== e.d) begin
        n_bad++;
        $display("FAIL %s: got valid_o=%b val_o=%h, expected valid_o=%b val_o=%h", e.nm, valid_o, val_o, e.v, e.d);
      end
    end
  end
  task automatic step(input bit rn, input bit v, input bit rw, input logic [15:0] k,
                      input logic [15:0] d, input bit ev, input logic [15:0] ed, input string nm);
    @(negedge clk);
    rst_n = rn;
    valid_i = v;
    rw_n_i = rw;
    key_i = k;
    val_i = d;
    exp_q.push_back('{ev, ed, nm});
  endtask
  task automatic rst_cycle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, "reset");
  endtask
  task automatic wr(input logic [15:0] k, input logic [15:0] d);
    step(1'b1, 1'b1, 1'b0, k, d, 1'b0, 16'h0, "write");
  endtask
  task automatic rd(input logic [15:0] k, input bit ev, input logic [15:0] ed, input string nm);
    step(1'b1, 1'b1, 1'b1, k, 16'h0, ev, ed, nm);
  endtask
  task automatic m_reset();
    order = {};
    for (int i = 0; i < 8; i++) begin
      mvld[i] = 1'b0;
      order.push_back(i);
    end
  endtask
  task automatic m_touch(input int t);
    foreach (order[j]) if (order[j] == t) begin
      order.delete(j);
      break;
    end
    order.push_back(t);
  endtask
  task automatic m_op(input bit rw, input logic [15:0] k, input logic [15:0] d);
    int h = -1;
    int t = -1;
    for (int i = 0; i < 8; i++) if (mvld[i] && mkey[i] == k) h = i;
    if (rw) begin
      if (h >= 0) m_touch(h);
      step(1'b1, 1'b1, 1'b1, k, 16'h0, h >= 0, h >= 0 ? mval[h] : 16'h0, "random_read");
    end else begin
      if (h >= 0) t = h;
      else begin
        for (int i = 7; i >= 0; i--) if (!mvld[i]) t = i;
        if (t < 0) t = order[0];
      end
      mvld[t] = 1'b1;
      mkey[t] = k;
      mval[t] = d;
      m_touch(t);
      step(1'b1, 1'b1, 1'b0, k, d, 1'b0, 16'h0, "random_write");
    end
  endtask
  initial begin
    rst_cycle();
    rst_cycle();
    wr(16'h0001, 16'hAAAA);
    rd(16'h0001, 1'b1, 16'hAAAA, "basic_hit");
    rd(16'h0002, 1'b0, 16'h0000, "basic_miss");
    rd(16'h0001, 1'b1, 16'hAAAA, "hit_again");
    step(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0, 16'h0, "idle_zero");
    rst_cycle();
    wr(16'h0010, 16'h1111);
    wr(16'h0010, 16'h2222);
    rd(16'h0010, 1'b1, 16'h2222, "same_key_write");
    @(negedge clk);
    n_cmp++;
    if ($countones(dut.vld) != 1) begin
      n_bad++;
      $display("FAIL one_entry_valid: got %0d valid entries, expected 1", $countones(dut.vld));
    end
    rst_cycle();
    for (int k = 0; k < 8; k++) wr(16'(k), 16'(k));
    rd(16'h0000, 1'b1, 16'h0000, "lru_read0");
    wr(16'h0008, 16'h0008);
    rd(16'h0001, 1'b0, 16'h0000, "evict_1_miss");
    rd(16'h0000, 1'b1, 16'h0000, "keep_0_hit");
    rd(16'h0008, 1'b1, 16'h0008, "new_8_hit");
    rd(16'h0002, 1'b1, 16'h0002, "keep_2_hit");
    rst_cycle();
    for (int k = 0; k < 8; k++) wr(16'(k), 16'(k));
    rd(16'h0099, 1'b0, 16'h0000, "miss_99");
    wr(16'h0009, 16'h0009);
    rd(16'h0000, 1'b0, 16'h0000, "evict_0_miss");
    rd(16'h0001, 1'b1, 16'h0001, "keep_1_hit");
    rd(16'h0009, 1'b1, 16'h0009, "new_9_hit");
    wr(16'h0003, 16'h3333);
    rd(16'h0003, 1'b1, 16'h3333, "write_hit_update");
    rd(16'h0001, 1'b1, 16'h0001, "no_alloc_1_kept");
    rst_cycle();
    wr(16'h0005, 16'h5555);
    step(1'b0, 1'b1, 1'b0, 16'h0006, 16'h6666, 1'b0, 16'h0, "reset_with_write");
    rd(16'h0005, 1'b0, 16'h0000, "post_reset_5");
    rd(16'h0006, 1'b0, 16'h0000, "post_reset_6");
    rst_cycle();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      logic [15:0] k = 16'($urandom_range(0, 11));
      m_op($urandom_range(0, 1) == 1, k, 16'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, "drain");
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
